// File: rtl/vip_mode_sequencer.sv
// Frame tracker that applies processing-mode requests at frame boundaries and checks frame geometry.
// Optional completed-frame counter: define VIP_FRAME_STATS_EN.
module vip_mode_sequencer #(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_frame_clken,
  input  logic [3:0]  cfg_mode,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic        err_clr,
  output logic [3:0]  active_mode,
  output logic        mode_update,
  output logic        frame_busy,
  output logic        geom_err,
  output logic [15:0] frame_cnt,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_BLANK  = 2'd2
  } state_t;

  localparam logic [10:0] HDISP   = 11'(IMG_HDISP);
  localparam logic [10:0] VDISP   = 11'(IMG_VDISP);
  localparam logic [10:0] CNT_MAX = 11'h7ff;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_vsync_d;
  logic        r_href_d;
  logic        w_vs_rise;
  logic        w_vs_fall;
  logic        w_href_rise;
  logic        w_href_fall;
  logic        r_pend_valid;
  logic [3:0]  r_pend_mode;
  logic [3:0]  r_active_mode;
  logic        r_mode_update;
  logic        w_cfg_accept;
  logic [10:0] r_pix_cnt;
  logic [10:0] r_line_cnt;
  logic [10:0] w_line_cnt_next;
  logic        w_in_active;
  logic        w_line_end;
  logic        w_pix_err;
  logic        w_line_err;
  logic        r_geom_err;

  assign w_vs_rise   = per_frame_vsync & ~r_vsync_d;
  assign w_vs_fall   = ~per_frame_vsync & r_vsync_d;
  assign w_href_rise = per_frame_href & ~r_href_d;
  assign w_href_fall = ~per_frame_href & r_href_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync_d <= 1'b0;
      r_href_d  <= 1'b0;
    end else begin
      r_vsync_d <= per_frame_vsync;
      r_href_d  <= per_frame_href;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_vs_rise) w_state_next = ST_ACTIVE;
      ST_ACTIVE: if (w_vs_fall) w_state_next = ST_BLANK;
      ST_BLANK:  if (w_vs_rise) w_state_next = ST_ACTIVE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  assign w_in_active = (r_state == ST_ACTIVE);

  // A request taken on a rise cycle lands in an empty slot, so it waits a full frame.
  assign w_cfg_accept = cfg_valid & ~r_pend_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_valid  <= 1'b0;
      r_pend_mode   <= 4'd0;
      r_active_mode <= 4'd0;
      r_mode_update <= 1'b0;
    end else begin
      r_mode_update <= 1'b0;
      if (w_vs_rise && r_pend_valid) begin
        r_active_mode <= r_pend_mode;
        r_mode_update <= (r_pend_mode != r_active_mode);
        r_pend_valid  <= 1'b0;
      end else if (w_cfg_accept) begin
        r_pend_mode  <= cfg_mode;
        r_pend_valid <= 1'b1;
      end
    end
  end

  // vsync dropping while href is still high closes the open line.
  assign w_line_end      = w_in_active & (w_href_fall | (w_vs_fall & per_frame_href));
  assign w_pix_err       = w_line_end & (r_pix_cnt != HDISP);
  assign w_line_cnt_next = (w_line_end && (r_line_cnt != CNT_MAX)) ? r_line_cnt + 11'd1
                                                                   : r_line_cnt;
  assign w_line_err      = w_in_active & w_vs_fall & (w_line_cnt_next != VDISP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_cnt <= 11'd0;
    end else if (w_href_rise) begin
      r_pix_cnt <= 11'(per_frame_clken);
    end else if (w_in_active && per_frame_href && per_frame_clken && (r_pix_cnt != CNT_MAX)) begin
      r_pix_cnt <= r_pix_cnt + 11'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_line_cnt <= 11'd0;
    else if (w_vs_rise) r_line_cnt <= 11'd0;
    else                r_line_cnt <= w_line_cnt_next;
  end

  // A new violation outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_geom_err <= 1'b0;
    else if (w_pix_err | w_line_err) r_geom_err <= 1'b1;
    else if (err_clr)                r_geom_err <= 1'b0;
  end

`ifdef VIP_FRAME_STATS_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_frame_cnt <= 16'd0;
    else if (w_in_active && w_vs_fall) r_frame_cnt <= r_frame_cnt + 16'd1;
  end

  assign frame_cnt = r_frame_cnt;
`else
  assign frame_cnt = 16'd0;
`endif

  assign cfg_ready   = ~r_pend_valid;
  assign active_mode = r_active_mode;
  assign mode_update = r_mode_update;
  assign frame_busy  = w_in_active;
  assign geom_err    = r_geom_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_vip_mode_sequencer.sv
// Bench for vip_mode_sequencer: small frame geometry, mode requests scored through an expected queue.
module tb_vip_mode_sequencer;

  localparam int HD = 12;
  localparam int VD = 5;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_BLANK  = 2'd2;

  logic        clk;
  logic        rst_n;
  logic        per_frame_vsync;
  logic        per_frame_href;
  logic        per_frame_clken;
  logic [3:0]  cfg_mode;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        err_clr;
  logic [3:0]  active_mode;
  logic        mode_update;
  logic        frame_busy;
  logic        geom_err;
  logic [15:0] frame_cnt;
  logic [1:0]  dbg_state;

  int          n_total;
  int          n_bad;
  logic [3:0]  exp_q[$];
  logic [3:0]  m_active;
  logic [3:0]  m_pend;
  bit          m_pend_valid;
  int          m_frames;

  vip_mode_sequencer #(.IMG_HDISP(HD), .IMG_VDISP(VD)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .per_frame_vsync (per_frame_vsync),
    .per_frame_href  (per_frame_href),
    .per_frame_clken (per_frame_clken),
    .cfg_mode        (cfg_mode),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .err_clr         (err_clr),
    .active_mode     (active_mode),
    .mode_update     (mode_update),
    .frame_busy      (frame_busy),
    .geom_err        (geom_err),
    .frame_cnt       (frame_cnt),
    .o_dbg_state     (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] exp_frames();
`ifdef VIP_FRAME_STATS_EN
    return 16'(m_frames);
`else
    return 16'd0;
`endif
  endfunction

  // Scoreboard: every mode_update pulse must match the next queued mode.
  always @(negedge clk) begin
    if (rst_n && mode_update === 1'b1) begin
      n_total++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL mode_update_pulse: unexpected pulse, active_mode=%0d", active_mode);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (active_mode !== e) begin
          n_bad++;
          $display("FAIL mode_update_value: got %0d want %0d", active_mode, e);
        end
      end
    end
  end

  // Driver tasks
  task automatic apply_reset();
    rst_n = 1'b0;
    m_active = 4'd0;
    m_pend_valid = 1'b0;
    m_frames = 0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    per_frame_vsync = 1'b0;
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    cfg_valid = 1'b0;
    err_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic model_rise();
    if (m_pend_valid) begin
      if (m_pend != m_active) exp_q.push_back(m_pend);
      m_active = m_pend;
      m_pend_valid = 1'b0;
    end
  endtask

  task automatic send_cfg(input logic [3:0] mode);
    int waited;
    waited = 0;
    while (cfg_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    n_total++;
    if (cfg_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL cfg_ready_timeout: got %b want 1", cfg_ready);
    end else begin
      cfg_valid = 1'b1;
      cfg_mode  = mode;
      m_pend = mode;
      m_pend_valid = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      n_total++;
      if (cfg_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL cfg_ready_after_accept: got %b want 0", cfg_ready);
      end
    end
  endtask

  task automatic drive_line(input int npix, input bit clr_at_end, input bit keep_open);
    int sent;
    sent = 0;
    per_frame_href = 1'b1;
    while (sent < npix) begin
      per_frame_clken = ($urandom_range(0, 3) != 0);
      if (per_frame_clken) sent++;
      @(negedge clk);
    end
    per_frame_clken = 1'b0;
    if (!keep_open) begin
      per_frame_href = 1'b0;
      err_clr = clr_at_end;
      @(negedge clk);
      err_clr = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic start_frame(input bit cfg_at_rise, input logic [3:0] cfg_m);
    per_frame_vsync = 1'b1;
    model_rise();
    if (cfg_at_rise) begin
      cfg_valid = 1'b1;
      cfg_mode  = cfg_m;
      m_pend = cfg_m;
      m_pend_valid = 1'b1;
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    n_total++;
    if (frame_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL frame_busy_in_frame: got %b want 1", frame_busy);
    end
    @(negedge clk);
  endtask

  task automatic end_frame();
    per_frame_vsync = 1'b0;
    m_frames++;
    repeat (4) @(negedge clk);
  endtask

  task automatic clean_frame();
    start_frame(1'b0, 4'd0);
    for (int l = 0; l < VD; l++) drive_line(HD, 1'b0, 1'b0);
    end_frame();
  endtask

  // Scenarios
  task automatic test_reset();
    apply_reset();
    n_total += 7;
    if (dbg_state !== S_IDLE)    begin n_bad++; $display("FAIL rst_state: got %0d want %0d", dbg_state, S_IDLE); end
    if (active_mode !== 4'd0)    begin n_bad++; $display("FAIL rst_active_mode: got %0d want 0", active_mode); end
    if (mode_update !== 1'b0)    begin n_bad++; $display("FAIL rst_mode_update: got %b want 0", mode_update); end
    if (frame_busy !== 1'b0)     begin n_bad++; $display("FAIL rst_frame_busy: got %b want 0", frame_busy); end
    if (geom_err !== 1'b0)       begin n_bad++; $display("FAIL rst_geom_err: got %b want 0", geom_err); end
    if (frame_cnt !== 16'd0)     begin n_bad++; $display("FAIL rst_frame_cnt: got %0d want 0", frame_cnt); end
    if (cfg_ready !== 1'b1)      begin n_bad++; $display("FAIL rst_cfg_ready: got %b want 1", cfg_ready); end
  endtask

  task automatic test_clean_frames();
    clean_frame();
    clean_frame();
    n_total += 4;
    if (geom_err !== 1'b0)         begin n_bad++; $display("FAIL clean_geom_err: got %b want 0", geom_err); end
    if (frame_cnt !== exp_frames()) begin n_bad++; $display("FAIL clean_frame_cnt: got %0d want %0d", frame_cnt, exp_frames()); end
    if (dbg_state !== S_BLANK)     begin n_bad++; $display("FAIL clean_state: got %0d want %0d", dbg_state, S_BLANK); end
    if (frame_busy !== 1'b0)       begin n_bad++; $display("FAIL clean_busy_blank: got %b want 0", frame_busy); end
  endtask

  task automatic test_cfg_blank();
    send_cfg(4'd1);
    repeat (2) @(negedge clk);
    n_total++;
    if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL cfg_blank_held: got %b want 0", cfg_ready); end
    start_frame(1'b0, 4'd0);
    n_total += 2;
    if (active_mode !== 4'd1) begin n_bad++; $display("FAIL cfg_blank_applied: got %0d want 1", active_mode); end
    if (cfg_ready !== 1'b1)   begin n_bad++; $display("FAIL cfg_blank_slot_free: got %b want 1", cfg_ready); end
    for (int l = 0; l < VD; l++) drive_line(HD, 1'b0, 1'b0);
    end_frame();
  endtask

  task automatic test_cfg_at_rise();
    start_frame(1'b1, 4'd2);
    n_total += 2;
    if (active_mode !== 4'd1) begin n_bad++; $display("FAIL rise_cfg_not_now: got %0d want 1", active_mode); end
    if (cfg_ready !== 1'b0)   begin n_bad++; $display("FAIL rise_cfg_pending: got %b want 0", cfg_ready); end
    for (int l = 0; l < VD; l++) drive_line(HD, 1'b0, 1'b0);
    end_frame();
    n_total++;
    if (active_mode !== 4'd1) begin n_bad++; $display("FAIL rise_cfg_frame_end: got %0d want 1", active_mode); end
    start_frame(1'b0, 4'd0);
    n_total++;
    if (active_mode !== 4'd2) begin n_bad++; $display("FAIL rise_cfg_next_frame: got %0d want 2", active_mode); end
    for (int l = 0; l < VD; l++) drive_line(HD, 1'b0, 1'b0);
    end_frame();
    // Same value again: slot is consumed, no pulse expected.
    send_cfg(4'd2);
    clean_frame();
    n_total += 2;
    if (cfg_ready !== 1'b1)   begin n_bad++; $display("FAIL same_mode_consumed: got %b want 1", cfg_ready); end
    if (active_mode !== 4'd2) begin n_bad++; $display("FAIL same_mode_value: got %0d want 2", active_mode); end
  endtask

  task automatic test_geom_err();
    start_frame(1'b0, 4'd0);
    drive_line(HD, 1'b0, 1'b0);
    n_total++;
    if (geom_err !== 1'b0) begin n_bad++; $display("FAIL geom_good_line: got %b want 0", geom_err); end
    drive_line(HD - 1, 1'b0, 1'b0);
    n_total++;
    if (geom_err !== 1'b1) begin n_bad++; $display("FAIL geom_short_line: got %b want 1", geom_err); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_total++;
    if (geom_err !== 1'b0) begin n_bad++; $display("FAIL geom_err_clr: got %b want 0", geom_err); end
    drive_line(HD - 1, 1'b1, 1'b0);
    n_total++;
    if (geom_err !== 1'b1) begin n_bad++; $display("FAIL geom_set_wins: got %b want 1", geom_err); end
    for (int l = 3; l < VD; l++) drive_line(HD, 1'b0, 1'b0);
    end_frame();
    n_total++;
    if (geom_err !== 1'b1) begin n_bad++; $display("FAIL geom_sticky: got %b want 1", geom_err); end
  endtask

  task automatic test_vsync_ends_line();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    start_frame(1'b0, 4'd0);
    for (int l = 0; l < VD - 1; l++) drive_line(HD, 1'b0, 1'b0);
    drive_line(HD, 1'b0, 1'b1);
    per_frame_vsync = 1'b0;
    m_frames++;
    @(negedge clk);
    per_frame_href = 1'b0;
    repeat (3) @(negedge clk);
    n_total += 3;
    if (geom_err !== 1'b0)          begin n_bad++; $display("FAIL vs_end_line_err: got %b want 0", geom_err); end
    if (dbg_state !== S_BLANK)      begin n_bad++; $display("FAIL vs_end_line_state: got %0d want %0d", dbg_state, S_BLANK); end
    if (frame_cnt !== exp_frames()) begin n_bad++; $display("FAIL vs_end_frame_cnt: got %0d want %0d", frame_cnt, exp_frames()); end
  endtask

  task automatic test_reset_mid_frame();
    start_frame(1'b0, 4'd0);
    drive_line(HD, 1'b0, 1'b0);
    send_cfg(4'd5);
    per_frame_href  = 1'b1;
    per_frame_clken = 1'b1;
    repeat (3) @(negedge clk);
    apply_reset();
    n_total += 5;
    if (dbg_state !== S_IDLE)  begin n_bad++; $display("FAIL midrst_state: got %0d want %0d", dbg_state, S_IDLE); end
    if (cfg_ready !== 1'b1)    begin n_bad++; $display("FAIL midrst_pend_dropped: got %b want 1", cfg_ready); end
    if (frame_busy !== 1'b0)   begin n_bad++; $display("FAIL midrst_busy: got %b want 0", frame_busy); end
    if (active_mode !== 4'd0)  begin n_bad++; $display("FAIL midrst_mode: got %0d want 0", active_mode); end
    if (frame_cnt !== 16'd0)   begin n_bad++; $display("FAIL midrst_frame_cnt: got %0d want 0", frame_cnt); end
    // Tail of an abandoned frame before any vsync rise: must be ignored.
    drive_line(3, 1'b0, 1'b0);
    drive_line(HD + 2, 1'b0, 1'b0);
    n_total++;
    if (geom_err !== 1'b0) begin n_bad++; $display("FAIL midrst_partial_ignored: got %b want 0", geom_err); end
    clean_frame();
    n_total += 3;
    if (geom_err !== 1'b0)          begin n_bad++; $display("FAIL midrst_clean_err: got %b want 0", geom_err); end
    if (active_mode !== 4'd0)       begin n_bad++; $display("FAIL midrst_no_apply: got %0d want 0", active_mode); end
    if (frame_cnt !== exp_frames()) begin n_bad++; $display("FAIL midrst_frame_cnt2: got %0d want %0d", frame_cnt, exp_frames()); end
  endtask

  initial begin
    n_total = 0;
    n_bad = 0;
    rst_n = 1'b0;
    per_frame_vsync = 1'b0;
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    cfg_mode  = 4'd0;
    cfg_valid = 1'b0;
    err_clr   = 1'b0;
    m_active = 4'd0;
    m_pend = 4'd0;
    m_pend_valid = 1'b0;
    m_frames = 0;

    test_reset();
    test_clean_frames();
    test_cfg_blank();
    test_cfg_at_rise();
    test_geom_err();
    test_vsync_ends_line();
    test_reset_mid_frame();

    repeat (2) @(negedge clk);
    n_total++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL mode_update_missing: got %0d leftover want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/vip_mode_sequencer.md
VIP_MODE_SEQUENCER -- requirements
Module: vip_mode_sequencer

Interface
REQ-001 SHALL have parameter IMG_HDISP, 640, expected active pixels per line.
REQ-002 SHALL have parameter IMG_VDISP, 480, expected active lines per frame.
REQ-003 SHALL have port clk  input  1  pixel clock; the only clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port per_frame_vsync  input  1  frame valid, active high.
REQ-006 SHALL have port per_frame_href  input  1  line valid, active high.
REQ-007 SHALL have port per_frame_clken  input  1  pixel strobe.
REQ-008 SHALL have port cfg_mode  input  4  requested processing mode.
REQ-009 SHALL have port cfg_valid  input  1  mode request strobe.
REQ-010 SHALL have port cfg_ready  output  1  pending slot free.
REQ-011 SHALL have port err_clr  input  1  clears geom_err.
REQ-012 SHALL have port active_mode  output  4  mode applied to the current frame; drives the pipeline mux.
REQ-013 SHALL have port mode_update  output  1  one-cycle pulse when active_mode changes.
REQ-014 SHALL have port frame_busy  output  1  high while inside a tracked frame.
REQ-015 SHALL have port geom_err  output  1  sticky frame-geometry error.
REQ-016 SHALL have port frame_cnt  output  16  completed-frame count.

Function
REQ-017 SHALL register vsync and href; rise = current high and registered low; fall = current low and registered high.
REQ-018 SHALL implement FSM IDLE -> ACTIVE on vsync rise; ACTIVE -> BLANK on vsync fall; BLANK -> ACTIVE on vsync rise; no other transitions.
REQ-019 SHALL drive frame_busy high only in ACTIVE.
REQ-020 SHALL hold one pending-mode register with a valid flag; cfg_ready = not pending_valid.
REQ-021 SHALL accept a request when cfg_valid and cfg_ready are both high at a clock edge; cfg_mode is captured into pending.
REQ-022 On a rise cycle with pending_valid set, SHALL load active_mode from pending and clear pending_valid; new active_mode and mode_update are visible on the next cycle.
REQ-023 SHALL pulse mode_update only when the applied value differs from the old active_mode; pending SHALL still be consumed when the values are equal.
REQ-024 A request accepted on a rise cycle with pending empty SHALL be held for the following frame, not the current one.
REQ-025 SHALL never change active_mode except on a rise cycle, and SHALL leave requests pending in IDLE until the first rise.
REQ-026 In ACTIVE, SHALL count per_frame_clken while per_frame_href is high in an 11-bit pixel counter that saturates at 2047 and resets at every href rise.
REQ-027 On href fall in ACTIVE, SHALL set geom_err if pixel count != IMG_HDISP, and SHALL increment an 11-bit line counter that saturates.
REQ-028 On a rise, SHALL clear the line counter; on vsync fall, SHALL set geom_err if line count != IMG_VDISP.
REQ-029 SHALL skip geometry checks while in IDLE, so a partial first frame is ignored.
REQ-030 SHALL keep geom_err set until err_clr; when set and clear occur in the same cycle, set SHALL win.
REQ-031 A vsync fall SHALL also end the line: an href still high at that point SHALL be checked as if href fell.

Reset
REQ-032 SHALL reset asynchronously on rst_n low, with state IDLE and all of the following cleared to 0: active_mode, mode_update, frame_busy, geom_err, frame_cnt, pending_valid, counters and edge registers.
REQ-033 SHALL abandon any in-progress frame on reset mid-frame and discard any pending request.

Configuration
REQ-034 With macro VIP_FRAME_STATS_EN defined, frame_cnt SHALL increment by 1 on each vsync fall from ACTIVE and SHALL wrap from 65535 to 0.
REQ-035 Without VIP_FRAME_STATS_EN, frame_cnt SHALL be constant 0 and no counter logic SHALL be built.

Verification
REQ-036 Reset, then two clean 640x480 frames -> geom_err = 0, frame_busy high during vsync, frame_cnt = 2 (macro on).
REQ-037 cfg_mode = 4'd1 is accepted during BLANK -> cfg_ready = 0 until the next rise; active_mode = 1 and a single mode_update pulse appear one cycle after the rise.
REQ-038 cfg_mode = 4'd2 is accepted exactly on a rise cycle -> active_mode stays unchanged that frame and becomes 2 at the next rise.
REQ-039 A frame containing one 639-pixel line -> geom_err = 1 after that href fall; err_clr pulse -> 0; err_clr in the same cycle as a new violation -> stays 1.
REQ-040 Reset asserted mid-frame with a request pending -> state IDLE, pending dropped (cfg_ready = 1), and a partial frame after release raises no geom_err.
